// File: rtl/jtframe_frac_pll.sv
// Fractional clock-enable synthesiser: NCH channels, each producing cen at
// clk*mul/div plus a half-period cenb, with a shared settle window after
// reset or any accepted reconfiguration.
module jtframe_frac_pll #(
  parameter int NCH      = 4,
  parameter int W        = 10,
  parameter int LOCK_CYC = 16,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_mul,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_phase,
  output logic           cfg_busy,
  output logic           cfg_err,
  output logic [NCH-1:0] cen,
  output logic [NCH-1:0] cenb,
  output logic           locked
);

  localparam int CW = $clog2(LOCK_CYC);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOCK_CYC - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          busy_reg, locked_reg, err_reg;

  // Writes are only taken while running; during settle they are dropped.
  logic accept, cfg_valid, run_step;
  assign accept    = (state_reg == ST_RUN) && cfg_we;
  assign cfg_valid = (cfg_mul != '0) && (cfg_div != '0) && (cfg_mul <= cfg_div);
  // The accept cycle is not an advancing cycle: every accumulator holds so
  // relative phase across channels survives the reconfiguration.
  assign run_step  = (state_reg == ST_RUN) && !cfg_we;

  // Settle/run sequencing.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_SETTLE: begin
        if (count_reg == '0) state_next = ST_RUN;
        else                 count_next = count_reg - 1'b1;
      end
      default: begin
        if (cfg_we) begin
          state_next = ST_SETTLE;
          count_next = CNT_INIT;
        end
      end
    endcase
  end

  // FSM state and registered status flags (all cleared during reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_SETTLE;
      count_reg  <= CNT_INIT;
      busy_reg   <= 1'b0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      busy_reg   <= (state_next == ST_SETTLE);
      locked_reg <= (state_next == ST_RUN);
      err_reg    <= accept && !cfg_valid;
    end
  end

  assign cfg_busy = busy_reg;
  assign locked   = locked_reg;
  assign cfg_err  = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] mul_reg, div_reg, acc_reg;
      logic         cen_reg, cenb_reg;
      logic [W:0]   sum, half;
      logic [W-1:0] acc_wrap;
      logic         wrap, sel;

      assign sel = accept && (cfg_ch == CHW'(gi));

      // Accumulator step; acc < div always holds, so the W-bit wrap result
      // of acc+mul-div is exact whenever a wrap occurs.
      always_comb begin
        sum      = {1'b0, acc_reg} + {1'b0, mul_reg};
        half     = {2'b00, div_reg[W-1:1]};
        wrap     = (sum >= {1'b0, div_reg});
        acc_wrap = acc_reg + mul_reg - div_reg;
      end

      // Channel configuration, accumulator and registered enable pulses.
      always_ff @(posedge clk) begin
        if (rst) begin
          mul_reg  <= '0;
          div_reg  <= '0;
          acc_reg  <= '0;
          cen_reg  <= 1'b0;
          cenb_reg <= 1'b0;
        end else begin
          cen_reg  <= 1'b0;
          cenb_reg <= 1'b0;
          if (sel) begin
            mul_reg <= cfg_valid ? cfg_mul : '0;
            div_reg <= cfg_div;
            acc_reg <= (cfg_phase < cfg_div) ? cfg_phase : '0;
          end else if (run_step && (mul_reg != '0)) begin
            if (wrap) begin
              acc_reg <= acc_wrap;
              cen_reg <= 1'b1;
            end else begin
              acc_reg <= sum[W-1:0];
            end
            // Half-period crossing; suppressed when mul is large enough that
            // it would merge with the main pulse.
            cenb_reg <= ({1'b0, acc_reg} < half) && (sum >= half) &&
                        ({1'b0, mul_reg} <= half);
          end
        end
      end

      assign cen[gi]  = cen_reg;
      assign cenb[gi] = cenb_reg;
    end
  endgenerate

endmodule
